ahb_apb_bridge_param: RTL and testbench
=======================================

Name: ahb_apb_bridge_param

Overview:
Single-clock, parametrised AHB-lite to APB bridge. It is the successor of the two-clock fixed 3-slave bridge.
Features added over that bridge: NUM_SLV generic slave decode, APB3 Pready wait states, Pslverr/decode errors mapped to a two-cycle AHB ERROR response, and a Pready timeout.
Sits between the AHB-lite interconnect and the APB peripheral cluster; one transfer outstanding at a time.

Parameters:
ADDR_W, 32, address width of Haddr/Paddr
DATA_W, 32, data width of Hwdata/Hrdata/Pwdata/Prdata
NUM_SLV, 3, number of APB slaves (one Pselx bit each), 1..16
BASE_ADDR, 32'h8000_0000, start of the APB window
SLV_LOG2, 10, log2 of bytes per slave region; slave i = BASE_ADDR + i*2^SLV_LOG2
TIMEOUT, 16, max ACCESS cycles with Pready=0 before abort; 0 disables timeout

Ports:
Hclk  in  1  single clock for AHB and APB sides
Hreset  in  1  asynchronous, active-high reset
Hwrite  in  1  AHB transfer direction, 1 = write
Hreadyin  in  1  AHB bus ready
Htrans  in  2  AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
Haddr  in  ADDR_W  AHB address
Hwdata  in  DATA_W  AHB write data (data phase)
Hreadyout  out  1  bridge ready / data-phase end
Hresp  out  2  00 OKAY, 01 ERROR
Hrdata  out  DATA_W  read data to AHB
Pselx  out  NUM_SLV  one-hot APB select
Penable  out  1  APB access phase
Pwrite  out  1  APB direction
Paddr  out  ADDR_W  APB address
Pwdata  out  DATA_W  APB write data
Prdata  in  DATA_W  APB read data
Pready  in  1  APB slave ready
Pslverr  in  1  APB slave error

Behaviour:
- Reset (async, any state): state=IDLE, Hreadyout=1, Hresp=00, Hrdata=0, Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, timeout counter=0.
- Accept condition: state IDLE and Hreadyout=1 and Hreadyin=1 and Htrans[1]=1. On acceptance, register Haddr and Hwrite. IDLE and BUSY transfers, or Hreadyin=0, are ignored with OKAY.
- Decode: idx = (Haddr-BASE_ADDR)>>SLV_LOG2. Valid iff Haddr>=BASE_ADDR and idx<NUM_SLV.
- Valid transfer: IDLE->SETUP. Invalid transfer: IDLE->ERR1 with no APB activity.
- SETUP (1 cycle): Pselx[idx]=1, Penable=0, Paddr/Pwrite from the registered values, Pwdata=Hwdata (pass-through), Hreadyout=0. Hwdata is registered into Pwdata at the end of SETUP. Next state ACCESS.
- ACCESS: Penable=1, Pselx held, Pwdata held, Hreadyout=0.
  - Pready=1 and Pslverr=0: capture Prdata into Hrdata (reads only), go to IDLE with Hreadyout=1 and Hresp=00.
  - Pready=1 and Pslverr=1: go to ERR1.
  - Pready=0: counter++. If TIMEOUT!=0 and counter reaches TIMEOUT, abort to ERR1 (Pselx and Penable drop).
- Pselx and Penable are cleared on every exit from ACCESS. The counter clears on entry to SETUP.
- ERR1: Hresp=01, Hreadyout=0. ERR2: Hresp=01, Hreadyout=1. ERR2->IDLE. No new transfer is accepted in ERR2.
- Latency, no wait states: address phase at edge N; SETUP in cycle N+1; ACCESS in N+2; Hreadyout=1 in N+3. Each Pready=0 cycle adds 1.
- Back-to-back: the IDLE cycle with Hreadyout=1 is the previous data phase end and may accept the next address phase (NONSEQ or SEQ, same handling).
- Hrdata holds its last read value until the next successful read. Writes do not alter Hrdata.
- Reset mid-ACCESS: APB outputs drop immediately and the transfer is lost.

Test Plan:
- Write 0x8000_0004, Hwdata=0xA5A5_0001, Pready=1 -> Pselx=001, Paddr=0x8000_0004, Pwrite=1, Pwdata=0xA5A5_0001 in SETUP/ACCESS; Hreadyout=1 three cycles after the address edge; Hresp=00.
- Read 0x8000_0808, Prdata=0x1234_5678, Pready low 3 ACCESS cycles -> Pselx=100, Penable high 4 cycles, Hrdata=0x1234_5678, Hreadyout low 5 cycles total.
- Access 0x8000_0C00 (beyond slave 2) -> Pselx stays 000; Hresp=01 two cycles, Hreadyout 0 then 1; then a write to 0x8000_0400 completes OKAY with Pselx=010.
- Write 0x8000_0010 with Pslverr=1 and Pready=1 -> ERR1/ERR2 ERROR response; Pselx cleared after the ACCESS cycle.
- Pready held 0 with TIMEOUT=16 -> Penable high exactly 16 cycles, then ERROR response. With TIMEOUT=0, no abort over 100 cycles.
- Four NONSEQ/SEQ writes 0x8000_0050..0x8000_005C back-to-back, plus Hreset asserted mid-ACCESS of a fifth -> four APB writes in order, data 0x77/0x88/0x99/0xAA; on reset all outputs return to reset values in the same cycle.

Source files
------------

// File: rtl/ahb_apb_bridge_param_if.sv
// AHB-lite / APB signal bundle for the parametrised bridge.
// Ports: AHB request and response, APB request and response.
//   slave  : bridge view (it is the AHB slave).
//   master : environment view (AHB master plus APB slaves).
interface ahb_apb_bridge_param_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 3
);
    logic              Hwrite;
    logic              Hreadyin;
    logic [1:0]        Htrans;
    logic [ADDR_W-1:0] Haddr;
    logic [DATA_W-1:0] Hwdata;
    logic              Hreadyout;
    logic [1:0]        Hresp;
    logic [DATA_W-1:0] Hrdata;

    logic [NUM_SLV-1:0] Pselx;
    logic               Penable;
    logic               Pwrite;
    logic [ADDR_W-1:0]  Paddr;
    logic [DATA_W-1:0]  Pwdata;
    logic [DATA_W-1:0]  Prdata;
    logic               Pready;
    logic               Pslverr;

    modport slave (
        input  Hwrite, Hreadyin, Htrans,
        input  Haddr, Hwdata,
        output Hreadyout, Hresp, Hrdata,
        output Pselx, Penable, Pwrite,
        output Paddr, Pwdata,
        input  Prdata, Pready, Pslverr
    );

    modport master (
        output Hwrite, Hreadyin, Htrans,
        output Haddr, Hwdata,
        input  Hreadyout, Hresp, Hrdata,
        input  Pselx, Penable, Pwrite,
        input  Paddr, Pwdata,
        output Prdata, Pready, Pslverr
    );
endinterface

// File: rtl/ahb_apb_bridge_param.sv
// Single-clock AHB-lite to APB3 bridge, NUM_SLV decoded slaves.
// Ports: Hclk, Hreset (async, active high), bus (slave modport).
module ahb_apb_bridge_param #(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter int              NUM_SLV   = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000,
    parameter int              SLV_LOG2  = 10,
    parameter int              TIMEOUT   = 16
) (
    input logic Hclk,
    input logic Hreset,
    ahb_apb_bridge_param_if.slave bus
);
    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {
        IDLE, SETUP, ACCESS, ERR1, ERR2
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [DATA_W-1:0] hrdata_q;

    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] idx;
    logic              hit;
    logic              accept;
    logic              hready;

    assign hready = (state == IDLE) || (state == ERR2);

    assign off = bus.Haddr - BASE_ADDR;
    assign idx = off >> SLV_LOG2;
    assign hit = (bus.Haddr >= BASE_ADDR) &&
                 (idx < ADDR_W'(NUM_SLV));

    // ERR2 also shows Hreadyout=1 but never accepts.
    assign accept = (state == IDLE) && hready &&
                    bus.Hreadyin && bus.Htrans[1];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = hit ? SETUP : ERR1;
                    cnt_n   = '0;
                end
            end
            SETUP: state_n = ACCESS;
            ACCESS: begin
                if (bus.Pready) begin
                    state_n = bus.Pslverr ? ERR1 : IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                    // Abort on the cycle the wait count hits TIMEOUT,
                    // so Penable is high exactly TIMEOUT cycles.
                    if (TIMEOUT != 0 &&
                        cnt_n == CNT_W'(TIMEOUT))
                        state_n = ERR1;
                end
            end
            ERR1:    state_n = ERR2;
            ERR2:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state    <= IDLE;
            cnt      <= '0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            idx_q    <= '0;
            pwdata_q <= '0;
            hrdata_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                paddr_q  <= bus.Haddr;
                pwrite_q <= bus.Hwrite;
                idx_q    <= IDX_W'(idx);
            end
            if (state == SETUP)
                pwdata_q <= bus.Hwdata;
            if (state == ACCESS && bus.Pready &&
                !bus.Pslverr && !pwrite_q)
                hrdata_q <= bus.Prdata;
        end
    end

    // APB controls derive from state, so an async reset
    // drops them in the same cycle.
    assign bus.Pselx =
        (state == SETUP || state == ACCESS) ?
        (NUM_SLV'(1) << idx_q) : '0;
    assign bus.Penable   = (state == ACCESS);
    assign bus.Pwrite    = pwrite_q;
    assign bus.Paddr     = paddr_q;
    // Data phase: Hwdata passes through during SETUP only.
    assign bus.Pwdata    = (state == SETUP) ?
                           bus.Hwdata : pwdata_q;
    assign bus.Hreadyout = hready;
    assign bus.Hresp     = (state == ERR1 || state == ERR2) ?
                           2'b01 : 2'b00;
    assign bus.Hrdata    = hrdata_q;
endmodule

// File: tb/tb_ahb_apb_bridge_param.sv
// Directed self-checking bench for ahb_apb_bridge_param.
// Ports: none (top); drives two bridges, TIMEOUT=16 and 0.
module tb_ahb_apb_bridge_param;
    logic Hclk;
    logic Hreset;
    int   n_cmp;
    int   n_err;

    logic [31:0] mon_a[$];
    logic [31:0] mon_d[$];

    ahb_apb_bridge_param_if #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLV(3)
    ) bus0 ();
    ahb_apb_bridge_param_if #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLV(3)
    ) bus1 ();

    ahb_apb_bridge_param #(.TIMEOUT(16)) u0 (
        .Hclk(Hclk), .Hreset(Hreset), .bus(bus0)
    );
    ahb_apb_bridge_param #(.TIMEOUT(0)) u1 (
        .Hclk(Hclk), .Hreset(Hreset), .bus(bus1)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    always @(negedge Hclk) begin
        if (!Hreset && bus0.Penable &&
            bus0.Pready && bus0.Pwrite) begin
            mon_a.push_back(bus0.Paddr);
            mon_d.push_back(bus0.Pwdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (bus0.Hreadyout !== 1'b1 ||
            bus0.Hresp !== 2'b00 ||
            bus0.Hrdata !== 32'h0 ||
            bus0.Pselx !== 3'b000 ||
            bus0.Penable !== 1'b0 ||
            bus0.Pwrite !== 1'b0 ||
            bus0.Paddr !== 32'h0 ||
            bus0.Pwdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset: rdy=%b resp=%b sel=%b en=%b addr=%h wd=%h rd=%h, need 1/00/000/0/0/0/0",
                     bus0.Hreadyout, bus0.Hresp, bus0.Pselx,
                     bus0.Penable, bus0.Paddr, bus0.Pwdata,
                     bus0.Hrdata);
        end
    endtask

    task automatic test_write();
        bus0.Pready  = 1'b1;
        bus0.Pslverr = 1'b0;
        bus0.Htrans  = 2'b10;
        bus0.Hwrite  = 1'b1;
        bus0.Haddr   = 32'h8000_0004;
        tick();
        bus0.Htrans = 2'b00;
        bus0.Hwdata = 32'hA5A5_0001;
        #1;
        n_cmp++;
        if (bus0.Pselx !== 3'b001 || bus0.Penable !== 1'b0 ||
            bus0.Paddr !== 32'h8000_0004 ||
            bus0.Pwrite !== 1'b1 ||
            bus0.Pwdata !== 32'hA5A5_0001 ||
            bus0.Hreadyout !== 1'b0) begin
            n_err++;
            $display("FAIL wr_setup: sel=%b en=%b addr=%h w=%b wd=%h rdy=%b, need 001/0/80000004/1/a5a50001/0",
                     bus0.Pselx, bus0.Penable, bus0.Paddr,
                     bus0.Pwrite, bus0.Pwdata, bus0.Hreadyout);
        end
        tick();
        bus0.Hwdata = 32'h0;
        #1;
        n_cmp++;
        if (bus0.Pselx !== 3'b001 || bus0.Penable !== 1'b1 ||
            bus0.Pwdata !== 32'hA5A5_0001 ||
            bus0.Hreadyout !== 1'b0) begin
            n_err++;
            $display("FAIL wr_access: sel=%b en=%b wd=%h rdy=%b, need 001/1/a5a50001/0",
                     bus0.Pselx, bus0.Penable,
                     bus0.Pwdata, bus0.Hreadyout);
        end
        tick();
        n_cmp++;
        if (bus0.Hreadyout !== 1'b1 || bus0.Hresp !== 2'b00 ||
            bus0.Pselx !== 3'b000 || bus0.Penable !== 1'b0) begin
            n_err++;
            $display("FAIL wr_done: rdy=%b resp=%b sel=%b en=%b, need 1/00/000/0",
                     bus0.Hreadyout, bus0.Hresp,
                     bus0.Pselx, bus0.Penable);
        end
    endtask

    task automatic test_read_wait();
        int  low;
        int  en;
        bit  done;
        bus0.Pready  = 1'b0;
        bus0.Pslverr = 1'b0;
        bus0.Prdata  = 32'h1234_5678;
        bus0.Htrans  = 2'b10;
        bus0.Hwrite  = 1'b0;
        bus0.Haddr   = 32'h8000_0808;
        tick();
        bus0.Htrans = 2'b00;
        n_cmp++;
        if (bus0.Pselx !== 3'b100 || bus0.Pwrite !== 1'b0) begin
            n_err++;
            $display("FAIL rd_setup: sel=%b w=%b, need 100/0",
                     bus0.Pselx, bus0.Pwrite);
        end
        low  = 1;
        en   = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (bus0.Hreadyout) begin
                done = 1'b1;
            end else begin
                low++;
                if (bus0.Penable) begin
                    en++;
                    if (en == 4) bus0.Pready = 1'b1;
                end
            end
        end
        n_cmp++;
        if (!done || low != 5 || en != 4) begin
            n_err++;
            $display("FAIL rd_wait: done=%b low=%0d en=%0d, need 1/5/4",
                     done, low, en);
        end
        n_cmp++;
        if (bus0.Hrdata !== 32'h1234_5678 ||
            bus0.Hresp !== 2'b00) begin
            n_err++;
            $display("FAIL rd_data: rd=%h resp=%b, need 12345678/00",
                     bus0.Hrdata, bus0.Hresp);
        end
    endtask

    task automatic test_decode_err();
        bus0.Pready = 1'b1;
        bus0.Htrans = 2'b10;
        bus0.Hwrite = 1'b0;
        bus0.Haddr  = 32'h8000_0C00;
        tick();
        bus0.Htrans = 2'b00;
        n_cmp++;
        if (bus0.Pselx !== 3'b000 || bus0.Penable !== 1'b0 ||
            bus0.Hresp !== 2'b01 || bus0.Hreadyout !== 1'b0) begin
            n_err++;
            $display("FAIL dec_err1: sel=%b en=%b resp=%b rdy=%b, need 000/0/01/0",
                     bus0.Pselx, bus0.Penable,
                     bus0.Hresp, bus0.Hreadyout);
        end
        tick();
        n_cmp++;
        if (bus0.Pselx !== 3'b000 || bus0.Hresp !== 2'b01 ||
            bus0.Hreadyout !== 1'b1) begin
            n_err++;
            $display("FAIL dec_err2: sel=%b resp=%b rdy=%b, need 000/01/1",
                     bus0.Pselx, bus0.Hresp, bus0.Hreadyout);
        end
        tick();
        n_cmp++;
        if (bus0.Hresp !== 2'b00 || bus0.Hreadyout !== 1'b1) begin
            n_err++;
            $display("FAIL dec_idle: resp=%b rdy=%b, need 00/1",
                     bus0.Hresp, bus0.Hreadyout);
        end
        bus0.Htrans = 2'b10;
        bus0.Hwrite = 1'b1;
        bus0.Haddr  = 32'h8000_0400;
        tick();
        bus0.Htrans = 2'b00;
        bus0.Hwdata = 32'h0000_0042;
        #1;
        n_cmp++;
        if (bus0.Pselx !== 3'b010 ||
            bus0.Paddr !== 32'h8000_0400) begin
            n_err++;
            $display("FAIL slv1_setup: sel=%b addr=%h, need 010/80000400",
                     bus0.Pselx, bus0.Paddr);
        end
        tick();
        tick();
        n_cmp++;
        if (bus0.Hreadyout !== 1'b1 || bus0.Hresp !== 2'b00 ||
            bus0.Hrdata !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL slv1_done: rdy=%b resp=%b rd=%h, need 1/00/12345678",
                     bus0.Hreadyout, bus0.Hresp, bus0.Hrdata);
        end
    endtask

    task automatic test_slverr();
        bus0.Pready  = 1'b1;
        bus0.Pslverr = 1'b1;
        bus0.Htrans  = 2'b10;
        bus0.Hwrite  = 1'b1;
        bus0.Haddr   = 32'h8000_0010;
        tick();
        bus0.Htrans = 2'b00;
        bus0.Hwdata = 32'h0000_0055;
        tick();
        n_cmp++;
        if (bus0.Pselx !== 3'b001 || bus0.Penable !== 1'b1) begin
            n_err++;
            $display("FAIL se_access: sel=%b en=%b, need 001/1",
                     bus0.Pselx, bus0.Penable);
        end
        tick();
        bus0.Pslverr = 1'b0;
        n_cmp++;
        if (bus0.Pselx !== 3'b000 || bus0.Penable !== 1'b0 ||
            bus0.Hresp !== 2'b01 || bus0.Hreadyout !== 1'b0) begin
            n_err++;
            $display("FAIL se_err1: sel=%b en=%b resp=%b rdy=%b, need 000/0/01/0",
                     bus0.Pselx, bus0.Penable,
                     bus0.Hresp, bus0.Hreadyout);
        end
        tick();
        n_cmp++;
        if (bus0.Hresp !== 2'b01 || bus0.Hreadyout !== 1'b1) begin
            n_err++;
            $display("FAIL se_err2: resp=%b rdy=%b, need 01/1",
                     bus0.Hresp, bus0.Hreadyout);
        end
        tick();
    endtask

    task automatic test_timeout();
        int en;
        bus0.Pready = 1'b0;
        bus0.Htrans = 2'b10;
        bus0.Hwrite = 1'b1;
        bus0.Haddr  = 32'h8000_0000;
        tick();
        bus0.Htrans = 2'b00;
        en = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!bus0.Penable) break;
            en++;
        end
        n_cmp++;
        if (en != 16 || bus0.Hresp !== 2'b01 ||
            bus0.Hreadyout !== 1'b0 || bus0.Pselx !== 3'b000) begin
            n_err++;
            $display("FAIL timeout: en=%0d resp=%b rdy=%b sel=%b, need 16/01/0/000",
                     en, bus0.Hresp, bus0.Hreadyout, bus0.Pselx);
        end
        tick();
        n_cmp++;
        if (bus0.Hresp !== 2'b01 || bus0.Hreadyout !== 1'b1) begin
            n_err++;
            $display("FAIL to_err2: resp=%b rdy=%b, need 01/1",
                     bus0.Hresp, bus0.Hreadyout);
        end
        tick();
        bus0.Pready = 1'b1;
    endtask

    task automatic test_timeout_off();
        int en;
        bus1.Pready = 1'b0;
        bus1.Htrans = 2'b10;
        bus1.Hwrite = 1'b1;
        bus1.Haddr  = 32'h8000_0000;
        tick();
        bus1.Htrans = 2'b00;
        en = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus1.Penable) en++;
        end
        n_cmp++;
        if (en != 100 || bus1.Penable !== 1'b1 ||
            bus1.Hresp !== 2'b00 || bus1.Hreadyout !== 1'b0) begin
            n_err++;
            $display("FAIL to_off: en=%0d pen=%b resp=%b rdy=%b, need 100/1/00/0",
                     en, bus1.Penable, bus1.Hresp, bus1.Hreadyout);
        end
        bus1.Pready = 1'b1;
        tick();
        n_cmp++;
        if (bus1.Hreadyout !== 1'b1 || bus1.Hresp !== 2'b00) begin
            n_err++;
            $display("FAIL to_off_done: rdy=%b resp=%b, need 1/00",
                     bus1.Hreadyout, bus1.Hresp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ea[4];
        logic [31:0] ed[4];
        ea = '{32'h8000_0050, 32'h8000_0054,
               32'h8000_0058, 32'h8000_005C};
        ed = '{32'h77, 32'h88, 32'h99, 32'hAA};
        mon_a.delete();
        mon_d.delete();
        bus0.Pready  = 1'b1;
        bus0.Pslverr = 1'b0;
        bus0.Hwrite  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus0.Htrans = (i == 0) ? 2'b10 : 2'b11;
            bus0.Haddr  = ea[i];
            tick();
            bus0.Htrans = 2'b00;
            bus0.Hwdata = ed[i];
            tick();
            tick();
            n_cmp++;
            if (bus0.Hreadyout !== 1'b1 || bus0.Hresp !== 2'b00) begin
                n_err++;
                $display("FAIL b2b_end%0d: rdy=%b resp=%b, need 1/00",
                         i, bus0.Hreadyout, bus0.Hresp);
            end
        end
        n_cmp++;
        if (mon_a.size() != 4) begin
            n_err++;
            $display("FAIL b2b_count: got %0d writes, need 4",
                     mon_a.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (mon_a[i] !== ea[i] || mon_d[i] !== ed[i]) begin
                    n_err++;
                    $display("FAIL b2b_wr%0d: addr=%h data=%h, need %h/%h",
                             i, mon_a[i], mon_d[i], ea[i], ed[i]);
                end
            end
        end
        n_cmp++;
        if (bus0.Hrdata !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL hrdata_hold: rd=%h, need 12345678",
                     bus0.Hrdata);
        end
        bus0.Pready = 1'b0;
        bus0.Htrans = 2'b11;
        bus0.Haddr  = 32'h8000_0060;
        tick();
        bus0.Htrans = 2'b00;
        bus0.Hwdata = 32'hBB;
        tick();
        n_cmp++;
        if (bus0.Penable !== 1'b1 || bus0.Pselx !== 3'b001) begin
            n_err++;
            $display("FAIL rst_pre: en=%b sel=%b, need 1/001",
                     bus0.Penable, bus0.Pselx);
        end
        #2;
        Hreset = 1'b1;
        #1;
        n_cmp++;
        if (bus0.Hreadyout !== 1'b1 ||
            bus0.Hresp !== 2'b00 ||
            bus0.Hrdata !== 32'h0 ||
            bus0.Pselx !== 3'b000 ||
            bus0.Penable !== 1'b0 ||
            bus0.Pwrite !== 1'b0 ||
            bus0.Paddr !== 32'h0 ||
            bus0.Pwdata !== 32'h0) begin
            n_err++;
            $display("FAIL rst_mid: rdy=%b resp=%b sel=%b en=%b addr=%h wd=%h rd=%h, need 1/00/000/0/0/0/0",
                     bus0.Hreadyout, bus0.Hresp, bus0.Pselx,
                     bus0.Penable, bus0.Paddr, bus0.Pwdata,
                     bus0.Hrdata);
        end
        tick();
        Hreset      = 1'b0;
        bus0.Pready = 1'b1;
        tick();
        n_cmp++;
        if (mon_a.size() != 4 || bus0.Penable !== 1'b0) begin
            n_err++;
            $display("FAIL rst_lost: writes=%0d en=%b, need 4/0",
                     mon_a.size(), bus0.Penable);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        Hreset = 1'b1;
        bus0.Hwrite = 1'b0;  bus1.Hwrite = 1'b0;
        bus0.Hreadyin = 1'b1; bus1.Hreadyin = 1'b1;
        bus0.Htrans = 2'b00; bus1.Htrans = 2'b00;
        bus0.Haddr  = '0;    bus1.Haddr  = '0;
        bus0.Hwdata = '0;    bus1.Hwdata = '0;
        bus0.Prdata = '0;    bus1.Prdata = '0;
        bus0.Pready = 1'b1;  bus1.Pready = 1'b1;
        bus0.Pslverr = 1'b0; bus1.Pslverr = 1'b0;
        tick();
        tick();
        test_reset();
        Hreset = 1'b0;
        tick();
        test_reset();
        test_write();
        test_read_wait();
        test_decode_err();
        test_slverr();
        test_timeout();
        test_timeout_off();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
